// File: rtl/seq_mac_mul.sv
// Sequential unsigned multiply-add p = x*y + u + v, one multiplier bit per clock.
// A single N-bit add-and-shift row is reused for M cycles behind a valid/ready handshake.
module seq_mac_mul #(
  parameter int N = 4,
  parameter int M = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     x,
  input  logic [N-1:0]     u,
  input  logic [M-1:0]     y,
  input  logic [M-1:0]     v,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N+M-1:0]   p,
  output logic             busy
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;
  localparam logic [CW-1:0] LAST_ROW = CW'(M - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     xr_q, xr_d;
  logic [M-1:0]     yr_q, yr_d;
  logic [M-1:0]     vr_q, vr_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [M-1:0]     lo_q, lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N+M-1:0]   p_q, p_d;

  logic [N-1:0]     row_x;
  logic [N:0]       sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      xr_q    <= '0;
      yr_q    <= '0;
      vr_q    <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      vr_q    <= vr_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  always_comb begin
    // v[i] enters as the carry-in of row i, so the row sum never exceeds N+1 bits.
    row_x = yr_q[cnt_q] ? xr_q : '0;
    sum   = {1'b0, row_x} + {1'b0, acc_q} + {{N{1'b0}}, vr_q[cnt_q]};

    state_d = state_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    vr_d    = vr_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    p_d     = p_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          xr_d    = x;
          yr_d    = y;
          vr_d    = v;
          acc_d   = u;
          lo_d    = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        lo_d[cnt_q] = sum[0];
        acc_d       = sum[N:1];
        if (cnt_q == LAST_ROW) begin
          // lo_d already carries this row's bit in its top position.
          p_d     = {sum[N:1], lo_d};
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign p         = p_q;

endmodule

// File: tb/tb_seq_mac_mul.sv
// Directed and randomised checks of seq_mac_mul at (4,3), (8,5) and (2,1).
module tb_seq_mac_mul;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [3:0] a_x, a_u;
  logic [2:0] a_y, a_v;
  logic [6:0] a_p;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [7:0]  b_x, b_u;
  logic [4:0]  b_y, b_v;
  logic [12:0] b_p;

  logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_busy;
  logic [1:0] c_x, c_u;
  logic [0:0] c_y, c_v;
  logic [2:0] c_p;

  seq_mac_mul #(.N(4), .M(3)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .x(a_x), .u(a_u), .y(a_y), .v(a_v), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .p(a_p), .busy(a_busy));

  seq_mac_mul #(.N(8), .M(5)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .x(b_x), .u(b_u), .y(b_y), .v(b_v), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .p(b_p), .busy(b_busy));

  seq_mac_mul #(.N(2), .M(1)) dut_c (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .x(c_x), .u(c_u), .y(c_y), .v(c_v), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .p(c_p), .busy(c_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_a(input logic [3:0] x, input logic [2:0] y, input logic [3:0] u,
                       input logic [2:0] v, input logic [63:0] exp, input string tag);
    int n;
    a_x = x; a_y = y; a_u = u; a_v = v; a_in_valid = 1'b1;
    n = 0;
    while (!a_in_ready && n < 20) begin tick(); n++; end
    chk({tag, "_acc_to"}, 64'(a_in_ready), 64'd1);
    tick();
    a_in_valid = 1'b0;
    n = 0;
    while (!a_out_valid && n < 20) begin tick(); n++; end
    chk({tag, "_done_to"}, 64'(a_out_valid), 64'd1);
    chk(tag, 64'(a_p), exp);
    if (a_out_ready) tick();
  endtask

  task automatic run_b(input logic [7:0] x, input logic [4:0] y, input logic [7:0] u,
                       input logic [4:0] v);
    int n;
    logic [63:0] exp;
    exp = 64'(x) * 64'(y) + 64'(u) + 64'(v);
    b_x = x; b_y = y; b_u = u; b_v = v; b_in_valid = 1'b1;
    n = 0;
    while (!b_in_ready && n < 20) begin tick(); n++; end
    tick();
    b_in_valid = 1'b0;
    n = 0;
    while (!b_out_valid && n < 20) begin tick(); n++; end
    chk("b_rand_p", 64'(b_p), exp);
    tick();
  endtask

  task automatic run_c(input logic [1:0] x, input logic [0:0] y, input logic [1:0] u,
                       input logic [0:0] v);
    logic [63:0] exp;
    exp = 64'(x) * 64'(y) + 64'(u) + 64'(v);
    c_x = x; c_y = y; c_u = u; c_v = v; c_in_valid = 1'b1;
    chk("c_in_ready", 64'(c_in_ready), 64'd1);
    tick();
    c_in_valid = 1'b0;
    chk("c_busy_run", 64'(c_busy), 64'd1);
    tick();
    chk("c_done_m1", 64'(c_out_valid), 64'd1);
    chk("c_p", 64'(c_p), exp);
    tick();
  endtask

  initial begin
    int n;
    int acc_cyc, prev_cyc;
    logic [3:0] bx [4];
    logic [2:0] by [4];
    logic [3:0] bu [4];
    logic [2:0] bv [4];

    reset = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_x = '0; a_y = '0; a_u = '0; a_v = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b1; b_x = '0; b_y = '0; b_u = '0; b_v = '0;
    c_in_valid = 1'b0; c_out_ready = 1'b1; c_x = '0; c_y = '0; c_u = '0; c_v = '0;
    tick(); tick();
    chk("rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_p", 64'(a_p), 64'd0);
    reset = 1'b0;
    tick();

    // 9*5 with cycle-exact latency checks.
    a_x = 4'd9; a_y = 3'd5; a_u = 4'd0; a_v = 3'd0; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    chk("lat_busy1", 64'(a_busy), 64'd1);
    chk("lat_in_ready1", 64'(a_in_ready), 64'd0);
    tick();
    chk("lat_busy2", 64'(a_busy), 64'd1);
    tick();
    chk("lat_busy3", 64'(a_busy), 64'd1);
    chk("lat_ov3", 64'(a_out_valid), 64'd0);
    tick();
    chk("lat_ov_m", 64'(a_out_valid), 64'd1);
    chk("lat_busy_done", 64'(a_busy), 64'd0);
    chk("lat_p45", 64'(a_p), 64'd45);
    tick();
    chk("lat_ov_drop", 64'(a_out_valid), 64'd0);
    chk("lat_idle", 64'(a_in_ready), 64'd1);

    run_a(4'd15, 3'd7, 4'd15, 3'd7, 64'd127, "max127");
    run_a(4'd0, 3'd0, 4'd0, 3'd0, 64'd0, "zero");
    run_a(4'd3, 3'd6, 4'd5, 3'd2, 64'd25, "mix25");

    // Backpressure in DONE with in_valid and x toggling.
    a_out_ready = 1'b0;
    run_a(4'd9, 3'd5, 4'd0, 3'd0, 64'd45, "bp_p");
    for (int i = 0; i < 5; i++) begin
      a_in_valid = ~a_in_valid;
      a_x = 4'($urandom);
      tick();
      chk("bp_hold_p", 64'(a_p), 64'd45);
      chk("bp_in_ready", 64'(a_in_ready), 64'd0);
      chk("bp_out_valid", 64'(a_out_valid), 64'd1);
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    tick();
    chk("bp_release_idle", 64'(a_in_ready), 64'd1);
    chk("bp_release_ov", 64'(a_out_valid), 64'd0);
    tick();
    chk("bp_no_2nd_accept", 64'(a_busy), 64'd0);

    // Reset on the second RUN cycle.
    a_x = 4'd15; a_y = 3'd7; a_u = 4'd15; a_v = 3'd7; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    tick();
    chk("mid_busy", 64'(a_busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("mid_rst_busy", 64'(a_busy), 64'd0);
    chk("mid_rst_ov", 64'(a_out_valid), 64'd0);
    chk("mid_rst_p", 64'(a_p), 64'd0);
    run_a(4'd3, 3'd2, 4'd1, 3'd1, 64'd8, "post_rst8");

    // Reset wins over in_valid.
    a_x = 4'd5; a_y = 3'd3; a_in_valid = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; a_in_valid = 1'b0;
    chk("rst_vs_valid_busy", 64'(a_busy), 64'd0);
    tick();
    chk("rst_vs_valid_busy2", 64'(a_busy), 64'd0);

    // Back-to-back: accepts must be M+2 = 5 cycles apart.
    bx = '{4'd9, 4'd15, 4'd7, 4'd1};
    by = '{3'd5, 3'd1, 3'd3, 3'd7};
    bu = '{4'd2, 4'd0, 4'd4, 4'd15};
    bv = '{3'd1, 3'd6, 3'd0, 3'd7};
    prev_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      a_x = bx[i]; a_y = by[i]; a_u = bu[i]; a_v = bv[i]; a_in_valid = 1'b1;
      n = 0;
      while (!a_in_ready && n < 20) begin tick(); n++; end
      tick();
      acc_cyc = cyc;
      a_in_valid = 1'b0;
      if (i > 0) chk("b2b_interval", 64'(acc_cyc - prev_cyc), 64'd5);
      prev_cyc = acc_cyc;
      n = 0;
      while (!a_out_valid && n < 20) begin tick(); n++; end
      chk("b2b_p", 64'(a_p), 64'(bx[i]) * 64'(by[i]) + 64'(bu[i]) + 64'(bv[i]));
      a_x = 4'($urandom); a_y = 3'($urandom); a_u = 4'($urandom); a_v = 3'($urandom);
      if (i < 3) begin
        a_in_valid = 1'b1;
        a_x = bx[i+1]; a_y = by[i+1]; a_u = bu[i+1]; a_v = bv[i+1];
      end
    end
    tick();

    run_b(8'd255, 5'd31, 8'd255, 5'd31);
    chk("b_max", 64'(b_p), 64'd8191);
    for (int i = 0; i < 1500; i++) begin
      run_b(8'($urandom), 5'($urandom), 8'($urandom), 5'($urandom));
    end

    for (int k = 0; k < 64; k++) begin
      logic [5:0] kk;
      kk = 6'(k);
      run_c(kk[1:0], kk[2:2], kk[4:3], kk[5:5]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
